// File: rtl/cpu_pkg.sv
// Shared types and encodings for the Thumb-subset core sequencer.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_FAULT   = 3'd5
   } state_e;

   // PC source select as produced by the decoder
   localparam logic [1:0] BR_LINK   = 2'b00;
   localparam logic [1:0] BR_COND   = 2'b01;
   localparam logic [1:0] BR_UNCOND = 2'b10;
   localparam logic [1:0] BR_NEXT   = 2'b11;

   // NZCV bit positions
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Decoder control word captured once per instruction
   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       noop;
      logic       br_ex;
      logic [3:0] keep_flags;
      logic [1:0] br_sel;
   } ctrl_t;

   // Per-flag select: masked bits take the ALU result, the rest hold
   function automatic logic [3:0] merge_flags(input logic [3:0] old_f,
                                              input logic [3:0] new_f,
                                              input logic [3:0] mask);
      logic [3:0] r;
      r[FLAG_N] = mask[FLAG_N] ? new_f[FLAG_N] : old_f[FLAG_N];
      r[FLAG_Z] = mask[FLAG_Z] ? new_f[FLAG_Z] : old_f[FLAG_Z];
      r[FLAG_C] = mask[FLAG_C] ? new_f[FLAG_C] : old_f[FLAG_C];
      r[FLAG_V] = mask[FLAG_V] ? new_f[FLAG_V] : old_f[FLAG_V];
      return r;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory handshakes. Counts cycles with a pending
// request and no ack; flags the cycle in which the count would reach TIMEOUT.
module mem_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam bit CHECK_ON = (TIMEOUT != 0);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins over counting
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expiry is only meaningful while still waiting, so an ack always wins
   always_comb begin
      timeout = CHECK_ON && en && !clr && (cnt_q == LAST);
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem/writeback,
// memory handshakes, NZCV flags and single-cycle architectural write strobes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_FETCH   | imem_req high; ack loads IR and moves on
// ST_DECODE  | one cycle; decoder outputs captured into ctrl_q
// ST_EXECUTE | one cycle; masked flag update from the ALU
// ST_MEM     | dmem_req high until ack (loads/stores only)
// ST_WB      | one cycle; register file and PC write strobes, count retire
// ST_FAULT   | memory ack timed out; everything quiet until reset
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             ir_load,
   input  logic             dec_reg_write,
   input  logic             dec_mem_write,
   input  logic             dec_mem_read,
   input  logic             dec_noop,
   input  logic             dec_br_ex,
   input  logic [3:0]       dec_keep_flags,
   input  logic [1:0]       dec_br_sel,
   input  logic [3:0]       alu_flags,
   output logic [3:0]       flags_q,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             rf_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             pc_from_reg,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   state_e           state_q;
   state_e           state_d;
   ctrl_t            ctrl_q;
   ctrl_t            ctrl_d;
   logic [3:0]       flags_d;
   logic [CNT_W-1:0] instr_count_q;
   logic [CNT_W-1:0] instr_count_d;

   logic             in_fetch;
   logic             in_mem;
   logic             mem_access;
   logic [3:0]       keep_eff;
   logic             wait_clr;
   logic             wait_en;
   logic             wait_timeout;

   // Noop suppresses memory traffic and flag updates regardless of decoder bits
   always_comb begin
      in_fetch   = (state_q == ST_FETCH);
      in_mem     = (state_q == ST_MEM);
      mem_access = (ctrl_q.mem_read | ctrl_q.mem_write) & ~ctrl_q.noop;
      keep_eff   = ctrl_q.noop ? 4'b0000 : ctrl_q.keep_flags;
      wait_clr   = ~(in_fetch | in_mem);
      wait_en    = (in_fetch & ~imem_ack) | (in_mem & ~dmem_ack);
   end

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait (
      .clk     (clk),
      .rst_n   (reset),
      .clr     (wait_clr),
      .en      (wait_en),
      .timeout (wait_timeout)
   );

   // Next-state, control capture, flag merge and retire count
   always_comb begin
      state_d       = state_q;
      ctrl_d        = ctrl_q;
      flags_d       = flags_q;
      instr_count_d = instr_count_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               state_d = ST_DECODE;
            end else if (wait_timeout) begin
               state_d = ST_FAULT;
            end
         end
         ST_DECODE: begin
            ctrl_d.reg_write  = dec_reg_write;
            ctrl_d.mem_write  = dec_mem_write;
            ctrl_d.mem_read   = dec_mem_read;
            ctrl_d.noop       = dec_noop;
            ctrl_d.br_ex      = dec_br_ex;
            ctrl_d.keep_flags = dec_keep_flags;
            ctrl_d.br_sel     = dec_br_sel;
            state_d           = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            flags_d = merge_flags(flags_q, alu_flags, keep_eff);
            state_d = mem_access ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            if (dmem_ack) begin
               state_d = ST_WB;
            end else if (wait_timeout) begin
               state_d = ST_FAULT;
            end
         end
         ST_WB: begin
            instr_count_d = instr_count_q + 1'b1;
            state_d       = ST_FETCH;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Sequencer state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_FETCH;
         ctrl_q        <= '0;
         flags_q       <= 4'b0000;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ctrl_q        <= ctrl_d;
         flags_q       <= flags_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Strobes decode straight from the state flop so they are glitch-free and
   // fall as soon as reset clears the state
   always_comb begin
      imem_req    = 1'b0;
      ir_load     = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      rf_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = BR_LINK;
      pc_from_reg = 1'b0;
      case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
            ir_load  = imem_ack;
         end
         ST_MEM: begin
            dmem_req = ~ctrl_q.noop;
            dmem_we  = ctrl_q.mem_write & ~ctrl_q.noop;
         end
         ST_WB: begin
            rf_we       = ctrl_q.reg_write & ~ctrl_q.noop;
            pc_we       = 1'b1;
            pc_sel      = ctrl_q.noop ? BR_NEXT : ctrl_q.br_sel;
            pc_from_reg = ctrl_q.br_ex & ~ctrl_q.noop;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      halted      = (state_q == ST_FAULT);
      instr_count = instr_count_q;
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed instruction table, randomized
// instruction stream against a phase-list model, timeout and reset cases.
module tb_cpu_sequencer;

   localparam int CW = 4;
   localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;

   typedef struct {
      bit       rw, mw, mr, noop, brex;
      bit [3:0] keep;
      bit [1:0] brsel;
      bit [3:0] alu;
      int       id;   // imem ack delay in cycles
      int       dd;   // dmem ack delay in cycles
      bit [3:0] exp_flags;
   } instr_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          imem_req, imem_ack, ir_load;
   logic          dec_reg_write, dec_mem_write, dec_mem_read, dec_noop, dec_br_ex;
   logic [3:0]    dec_keep_flags;
   logic [1:0]    dec_br_sel;
   logic [3:0]    alu_flags, flags_q;
   logic          dmem_req, dmem_we, dmem_ack;
   logic          rf_we, pc_we, pc_from_reg, halted;
   logic [1:0]    pc_sel;
   logic [CW-1:0] instr_count;

   int checks = 0;
   int failures = 0;
   bit [3:0] m_flags;
   int       m_count;

   cpu_sequencer #(.TIMEOUT(16), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load),
      .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
      .dec_mem_read(dec_mem_read), .dec_noop(dec_noop), .dec_br_ex(dec_br_ex),
      .dec_keep_flags(dec_keep_flags), .dec_br_sel(dec_br_sel),
      .alu_flags(alu_flags), .flags_q(flags_q),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .pc_from_reg(pc_from_reg),
      .halted(halted), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic scramble_inputs();
      dec_reg_write  = 1'($urandom);
      dec_mem_write  = 1'($urandom);
      dec_mem_read   = 1'($urandom);
      dec_noop       = 1'($urandom);
      dec_br_ex      = 1'($urandom);
      dec_keep_flags = 4'($urandom);
      dec_br_sel     = 2'($urandom);
      alu_flags      = 4'($urandom);
      imem_ack       = 1'($urandom);
      dmem_ack       = 1'($urandom);
   endtask

   // Called 2 time units after a rising edge; drives one cycle, checks the
   // strobes mid-cycle, and returns 2 units after the next rising edge.
   task automatic do_cycle(input int ph, input instr_t r, input bit hit);
      logic [9:0] e, a;
      scramble_inputs();
      case (ph)
         PH_F: imem_ack = hit;
         PH_D: begin
            dec_reg_write = r.rw; dec_mem_write = r.mw; dec_mem_read = r.mr;
            dec_noop = r.noop; dec_br_ex = r.brex;
            dec_keep_flags = r.keep; dec_br_sel = r.brsel;
         end
         PH_E: alu_flags = r.alu;
         PH_M: dmem_ack = hit;
         default: ;
      endcase
      #2;
      e = '0;
      case (ph)
         PH_F: begin e[9] = 1'b1; e[8] = hit; end
         PH_M: begin e[7] = 1'b1; e[6] = r.mw; end
         PH_W: begin
            e[5]   = r.rw & ~r.noop;
            e[4]   = 1'b1;
            e[3:2] = r.noop ? 2'b11 : r.brsel;
            e[1]   = r.noop ? 1'b0 : r.brex;
         end
         default: ;
      endcase
      a = {imem_req, ir_load, dmem_req, (ph == PH_M) ? dmem_we : 1'b0, rf_we, pc_we,
           (ph == PH_W) ? pc_sel : 2'b00, (ph == PH_W) ? pc_from_reg : 1'b0, halted};
      chk($sformatf("strobes phase=%0d", ph), 32'(a), 32'(e));
      @(posedge clk);
      #2;
   endtask

   // Runs one instruction as a list of phases and updates the model
   task automatic run_instr(input instr_t r, input bit use_table_flags);
      int ph_list[$];
      bit hit_list[$];
      bit mem;
      mem = (r.mr | r.mw) & ~r.noop;
      for (int i = 0; i <= r.id; i++) begin ph_list.push_back(PH_F); hit_list.push_back(i == r.id); end
      ph_list.push_back(PH_D); hit_list.push_back(1'b0);
      ph_list.push_back(PH_E); hit_list.push_back(1'b0);
      if (mem)
         for (int i = 0; i <= r.dd; i++) begin ph_list.push_back(PH_M); hit_list.push_back(i == r.dd); end
      ph_list.push_back(PH_W); hit_list.push_back(1'b0);
      foreach (ph_list[k]) do_cycle(ph_list[k], r, hit_list[k]);
      if (!r.noop) m_flags = (m_flags & ~r.keep) | (r.alu & r.keep);
      m_count = (m_count + 1) % (1 << CW);
      chk("flags_q", 32'(flags_q), 32'(use_table_flags ? r.exp_flags : m_flags));
      chk("instr_count", 32'(instr_count), 32'(m_count));
      chk("halted", 32'(halted), 32'd0);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      scramble_inputs();
      imem_ack = 1'b0; dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      m_flags = 4'b0000;
      m_count = 0;
   endtask

   instr_t tbl[8];
   instr_t r;

   initial begin
      //        rw mw mr np bx keep     br     alu      id  dd exp
      tbl[0] = '{1, 0, 0, 0, 0, 4'b1111, 2'b11, 4'b0110, 0,  0, 4'b0110}; // ADDS
      tbl[1] = '{1, 0, 1, 0, 0, 4'b0000, 2'b11, 4'b1111, 0,  3, 4'b0110}; // LDR, dmem wait 3
      tbl[2] = '{0, 1, 0, 0, 0, 4'b0000, 2'b11, 4'b1001, 0,  0, 4'b0110}; // STR
      tbl[3] = '{1, 0, 0, 0, 0, 4'b1100, 2'b11, 4'b1011, 0,  0, 4'b1010}; // ANDS
      tbl[4] = '{1, 1, 0, 1, 0, 4'b1111, 2'b00, 4'b0101, 0,  0, 4'b1010}; // NOOP
      tbl[5] = '{0, 0, 0, 0, 0, 4'b0000, 2'b01, 4'b1111, 15, 0, 4'b1010}; // B cond, ack on timeout edge
      tbl[6] = '{0, 0, 1, 0, 0, 4'b0000, 2'b11, 4'b0000, 1, 15, 4'b1010}; // LDR, dmem ack on timeout edge
      tbl[7] = '{1, 0, 0, 0, 1, 4'b1111, 2'b10, 4'b0001, 2,  0, 4'b0001}; // BX + flag write

      // Reset values
      reset = 1'b0;
      scramble_inputs();
      repeat (2) @(posedge clk);
      #4;
      chk("reset imem_req", 32'(imem_req), 32'd1);
      chk("reset strobes", 32'({ir_load & 1'b0, dmem_req, rf_we, pc_we, halted}), 32'd0);
      chk("reset flags_q", 32'(flags_q), 32'd0);
      chk("reset instr_count", 32'(instr_count), 32'd0);

      // Fetch that never gets an ack faults after 16 wait cycles
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         scramble_inputs();
         imem_ack = 1'b0;
         #2;
         chk("timeout waiting imem_req", 32'({imem_req, halted}), 32'b10);
         @(posedge clk);
         #2;
      end
      for (int i = 0; i < 4; i++) begin
         scramble_inputs();
         imem_ack = 1'b1; dmem_ack = 1'b1;
         #2;
         chk("fault strobes", 32'({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we}), 32'd0);
         chk("fault halted", 32'(halted), 32'd1);
         @(posedge clk);
         #2;
      end

      // Directed table
      apply_reset();
      foreach (tbl[i]) run_instr(tbl[i], 1'b1);

      // Randomized instruction stream
      for (int n = 0; n < 40; n++) begin
         r.rw    = 1'($urandom);
         r.mr    = ($urandom_range(0, 3) == 0);
         r.mw    = !r.mr && ($urandom_range(0, 3) == 0);
         r.noop  = ($urandom_range(0, 7) == 0);
         r.brex  = ($urandom_range(0, 5) == 0);
         r.keep  = 4'($urandom);
         r.brsel = 2'($urandom);
         r.alu   = 4'($urandom);
         r.id    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1);
         r.dd    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1);
         r.exp_flags = 4'b0000;
         run_instr(r, 1'b0);
      end

      // Reset in the middle of a data access
      apply_reset();
      run_instr(tbl[0], 1'b0);
      r = tbl[1];
      r.dd = 5;
      do_cycle(PH_F, r, 1'b1);
      do_cycle(PH_D, r, 1'b0);
      do_cycle(PH_E, r, 1'b0);
      scramble_inputs();
      dmem_ack = 1'b0;
      #2;
      chk("mem dmem_req before reset", 32'(dmem_req), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("async drop dmem_req", 32'({dmem_req, rf_we, pc_we}), 32'd0);
      chk("reset state fetch", 32'(imem_req), 32'd1);
      chk("reset mid flags_q", 32'(flags_q), 32'd0);
      chk("reset mid instr_count", 32'(instr_count), 32'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      m_flags = 4'b0000;
      m_count = 0;
      run_instr(tbl[0], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case anything above stalls
   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
